// File: rtl/commit_stage.sv
// commit_stage
// Final in-order pipeline stage. Retires the execute stage's result bundle
// by writing the integer / FP register files, hands traps and trap-returns
// to the CSR unit through a request/acknowledge handshake, and keeps the
// 64-bit retired-instruction counter (minstret).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_*                     execute-stage result bundle
//   int_we/waddr/wdata       integer register-file write port (combinational)
//   fp_we/waddr/wdata        FP register-file write port (combinational)
//   trap_req, trap_cause,
//   trap_value, trap_pc      registered trap-entry request to the CSR unit
//   trap_return_req,
//   trap_return_priv         registered trap-return request
//   csr_ack                  CSR unit accepted the pending request
//   stall_req                handshake in progress, upstream must hold
//   flush_req                one-cycle pulse that flushes younger ops
//   instret_we/wdata         CSR write of minstret
//   instret                  retired-instruction count
module commit_stage #(
  parameter int XLEN        = 32,
  parameter int CAUSE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_reg_write,
  input  logic                   in_dst_fp,
  input  logic [4:0]             in_dst_addr,
  input  logic [XLEN-1:0]        in_int_value,
  input  logic [63:0]            in_fp_value,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   in_trap_valid,
  input  logic [CAUSE_WIDTH-1:0] in_trap_cause,
  input  logic [XLEN-1:0]        in_trap_value,
  input  logic                   in_trap_return,
  input  logic [1:0]             in_return_priv,
  output logic                   int_we,
  output logic [4:0]             int_waddr,
  output logic [XLEN-1:0]        int_wdata,
  output logic                   fp_we,
  output logic [4:0]             fp_waddr,
  output logic [63:0]            fp_wdata,
  output logic                   trap_req,
  output logic [CAUSE_WIDTH-1:0] trap_cause,
  output logic [XLEN-1:0]        trap_value,
  output logic [XLEN-1:0]        trap_pc,
  output logic                   trap_return_req,
  output logic [1:0]             trap_return_priv,
  input  logic                   csr_ack,
  output logic                   stall_req,
  output logic                   flush_req,
  input  logic                   instret_we,
  input  logic [63:0]            instret_wdata,
  output logic [63:0]            instret
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_ACK = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   trap_req_q, trap_req_d;
  logic                   ret_req_q, ret_req_d;
  logic [CAUSE_WIDTH-1:0] cause_q, cause_d;
  logic [XLEN-1:0]        value_q, value_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [1:0]             priv_q, priv_d;
  logic [63:0]            instret_q, instret_d;
  logic                   retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      trap_req_q <= 1'b0;
      ret_req_q  <= 1'b0;
      cause_q    <= '0;
      value_q    <= '0;
      pc_q       <= '0;
      priv_q     <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      trap_req_q <= trap_req_d;
      ret_req_q  <= ret_req_d;
      cause_q    <= cause_d;
      value_q    <= value_d;
      pc_q       <= pc_d;
      priv_q     <= priv_d;
      instret_q  <= instret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trap_req_d = trap_req_q;
    ret_req_d  = ret_req_q;
    cause_d    = cause_q;
    value_d    = value_q;
    pc_d       = pc_q;
    priv_d     = priv_q;
    retire     = 1'b0;
    int_we     = 1'b0;
    int_waddr  = '0;
    int_wdata  = '0;
    fp_we      = 1'b0;
    fp_waddr   = '0;
    fp_wdata   = '0;

    case (state_q)
      RUN: begin
        int_waddr = in_dst_addr;
        int_wdata = in_int_value;
        fp_waddr  = in_dst_addr;
        fp_wdata  = in_fp_value;
        if (in_valid) begin
          if (in_trap_valid || in_trap_return) begin
            cause_d    = in_trap_cause;
            value_d    = in_trap_value;
            pc_d       = in_pc;
            priv_d     = in_return_priv;
            // A simultaneous trap and return resolves to the trap.
            trap_req_d = in_trap_valid;
            ret_req_d  = ~in_trap_valid;
            state_d    = WAIT_ACK;
          end else begin
            retire = 1'b1;
            // x0 is hardwired to zero; f0 is an ordinary register.
            int_we = in_reg_write & ~in_dst_fp & (in_dst_addr != 5'd0);
            fp_we  = in_reg_write & in_dst_fp;
          end
        end
      end
      WAIT_ACK: begin
        if (csr_ack) begin
          trap_req_d = 1'b0;
          ret_req_d  = 1'b0;
          // MRET/SRET completes when the CSR unit takes it; a trap never retires.
          retire     = ret_req_q;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d    = RUN;
        trap_req_d = 1'b0;
        ret_req_d  = 1'b0;
      end
    endcase

    // A CSR write overrides any same-cycle retire.
    if (instret_we) begin
      instret_d = instret_wdata;
    end else begin
      instret_d = instret_q + {63'd0, retire};
    end
  end

  assign trap_req         = trap_req_q;
  assign trap_cause       = cause_q;
  assign trap_value       = value_q;
  assign trap_pc          = pc_q;
  assign trap_return_req  = ret_req_q;
  assign trap_return_priv = priv_q;
  assign stall_req        = (state_q == WAIT_ACK);
  assign flush_req        = (state_q == FLUSH);
  assign instret          = instret_q;

endmodule

// File: tb/tb_commit_stage.sv
module tb_commit_stage;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_reg_write, in_dst_fp;
  logic [4:0]    in_dst_addr;
  logic [31:0]   in_int_value;
  logic [63:0]   in_fp_value;
  logic [31:0]   in_pc;
  logic          in_trap_valid;
  logic [3:0]    in_trap_cause;
  logic [31:0]   in_trap_value;
  logic          in_trap_return;
  logic [1:0]    in_return_priv;
  logic          int_we, fp_we;
  logic [4:0]    int_waddr, fp_waddr;
  logic [31:0]   int_wdata;
  logic [63:0]   fp_wdata;
  logic          trap_req, trap_return_req;
  logic [3:0]    trap_cause;
  logic [31:0]   trap_value, trap_pc;
  logic [1:0]    trap_return_priv;
  logic          csr_ack, stall_req, flush_req;
  logic          instret_we;
  logic [63:0]   instret_wdata, instret;

  int checks = 0;
  int errors = 0;

  // Reference model: where the stage is in the trap hand-off, what it holds,
  // and how many instructions have retired.
  int          m_phase;   // 0 accepting, 1 awaiting CSR, 2 flushing
  bit          m_ret;
  logic [3:0]  m_cause;
  logic [31:0] m_value, m_pc;
  logic [1:0]  m_priv;
  logic [63:0] m_instret;

  commit_stage #(.XLEN(XLEN), .CAUSE_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_dst_fp(in_dst_fp),
    .in_dst_addr(in_dst_addr), .in_int_value(in_int_value), .in_fp_value(in_fp_value),
    .in_pc(in_pc), .in_trap_valid(in_trap_valid), .in_trap_cause(in_trap_cause),
    .in_trap_value(in_trap_value), .in_trap_return(in_trap_return),
    .in_return_priv(in_return_priv),
    .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata),
    .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_value(trap_value),
    .trap_pc(trap_pc), .trap_return_req(trap_return_req),
    .trap_return_priv(trap_return_priv), .csr_ack(csr_ack),
    .stall_req(stall_req), .flush_req(flush_req),
    .instret_we(instret_we), .instret_wdata(instret_wdata), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_reg_write = 0; in_dst_fp = 0; in_dst_addr = 0;
    in_int_value = 0; in_fp_value = 0; in_pc = 0;
    in_trap_valid = 0; in_trap_cause = 0; in_trap_value = 0;
    in_trap_return = 0; in_return_priv = 0;
    csr_ack = 0; instret_we = 0; instret_wdata = 0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_ret = 0; m_cause = 0; m_value = 0; m_pc = 0; m_priv = 0;
    m_instret = 0;
  endtask

  function automatic bit is_normal();
    return (m_phase == 0) && in_valid && !in_trap_valid && !in_trap_return;
  endfunction

  task automatic check_all(input string tag);
    bit e_iwe, e_fwe;
    e_iwe = is_normal() && in_reg_write && !in_dst_fp && (in_dst_addr != 0);
    e_fwe = is_normal() && in_reg_write && in_dst_fp;
    chk({tag, ".int_we"}, {63'd0, int_we}, {63'd0, e_iwe});
    chk({tag, ".fp_we"},  {63'd0, fp_we},  {63'd0, e_fwe});
    if (e_iwe) begin
      chk({tag, ".int_waddr"}, {59'd0, int_waddr}, {59'd0, in_dst_addr});
      chk({tag, ".int_wdata"}, {32'd0, int_wdata}, {32'd0, in_int_value});
    end
    if (e_fwe) begin
      chk({tag, ".fp_waddr"}, {59'd0, fp_waddr}, {59'd0, in_dst_addr});
      chk({tag, ".fp_wdata"}, fp_wdata, in_fp_value);
    end
    chk({tag, ".trap_req"},  {63'd0, trap_req},        {63'd0, (m_phase == 1) && !m_ret});
    chk({tag, ".ret_req"},   {63'd0, trap_return_req}, {63'd0, (m_phase == 1) && m_ret});
    chk({tag, ".stall"},     {63'd0, stall_req},       {63'd0, m_phase == 1});
    chk({tag, ".flush"},     {63'd0, flush_req},       {63'd0, m_phase == 2});
    chk({tag, ".instret"},   instret, m_instret);
    if (m_phase == 1) begin
      chk({tag, ".cause"}, {60'd0, trap_cause}, {60'd0, m_cause});
      chk({tag, ".value"}, {32'd0, trap_value}, {32'd0, m_value});
      chk({tag, ".pc"},    {32'd0, trap_pc},    {32'd0, m_pc});
      if (m_ret) chk({tag, ".priv"}, {62'd0, trap_return_priv}, {62'd0, m_priv});
    end
  endtask

  // Apply the spec's rules for what happens at a rising edge.
  task automatic model_edge();
    bit retire;
    retire = is_normal() || ((m_phase == 1) && csr_ack && m_ret);
    if (instret_we) m_instret = instret_wdata;
    else if (retire) m_instret = m_instret + 64'd1;
    case (m_phase)
      0: if (in_valid && (in_trap_valid || in_trap_return)) begin
           m_cause = in_trap_cause; m_value = in_trap_value; m_pc = in_pc;
           m_priv = in_return_priv; m_ret = !in_trap_valid; m_phase = 1;
         end
      1: if (csr_ack) m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  // Inputs are set at posedge+1; check at the falling edge, then advance.
  task automatic cycle(input string tag);
    #4;
    check_all(tag);
    $display("%s: v=%0d tv=%0d tr=%0d ack=%0d phase=%0d instret=%h",
             tag, in_valid, in_trap_valid, in_trap_return, csr_ack, m_phase, instret);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic int_write(input logic [4:0] a, input logic [31:0] d);
    idle_inputs(); in_valid = 1; in_reg_write = 1; in_dst_addr = a; in_int_value = d;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    #2;
    chk("reset.trap_req", {63'd0, trap_req}, 64'd0);
    chk("reset.instret", instret, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // Normal writes
    int_write(5'd5, 32'h1234);                    cycle("int_x5");
    idle_inputs(); in_valid = 1; in_reg_write = 1; in_dst_fp = 1;
    in_dst_addr = 0; in_fp_value = 64'h3FF0000000000000; cycle("fp_f0");
    int_write(5'd0, 32'hABCD);                    cycle("int_x0");
    idle_inputs();                                cycle("idle");
    chk("instret_after_3", instret, 64'd3);

    // Trap with ack in the third request cycle
    idle_inputs(); in_valid = 1; in_trap_valid = 1; in_trap_cause = 4'd2;
    in_trap_value = 32'hDEAD; in_pc = 32'h80000010; cycle("trap_c0");
    idle_inputs();                                cycle("trap_c1");
    int_write(5'd7, 32'h55);                      cycle("trap_c2");
    idle_inputs(); csr_ack = 1;                   cycle("trap_c3");
    idle_inputs();                                cycle("trap_c4");
    chk("trap_c5_run_no_stall", {63'd0, stall_req}, 64'd0);
    cycle("trap_c5");
    chk("trap_instret_unchanged", instret, 64'd3);

    // Trap-return, also with both flags (trap wins)
    idle_inputs(); in_valid = 1; in_trap_return = 1; in_return_priv = 2'd3; cycle("mret_c0");
    chk("mret_priv", {62'd0, trap_return_priv}, 64'd3);
    idle_inputs(); csr_ack = 1;                   cycle("mret_ack");
    idle_inputs();                                cycle("mret_flush");
    chk("mret_retired", instret, 64'd4);
    idle_inputs(); in_valid = 1; in_trap_valid = 1; in_trap_return = 1;
    in_trap_cause = 4'd9;                         cycle("both_c0");
    idle_inputs(); csr_ack = 1;                   cycle("both_ack");
    idle_inputs();                                cycle("both_flush");

    // instret boundaries
    idle_inputs(); instret_we = 1; instret_wdata = 64'hFFFF_FFFF_FFFF_FFFF; cycle("preload");
    int_write(5'd1, 32'h1);                       cycle("wrap_retire");
    idle_inputs();                                cycle("wrap_check");
    chk("instret_wrap", instret, 64'd0);
    int_write(5'd2, 32'h2); instret_we = 1; instret_wdata = 64'd7; cycle("we_priority");
    idle_inputs();                                cycle("we_check");
    chk("instret_we_priority", instret, 64'd7);

    // Asynchronous reset during WAIT_ACK
    idle_inputs(); in_valid = 1; in_trap_valid = 1; in_trap_cause = 4'd5; cycle("ar_trap");
    idle_inputs(); rst = 1; #1;
    chk("ar.trap_req", {63'd0, trap_req}, 64'd0);
    chk("ar.stall",    {63'd0, stall_req}, 64'd0);
    chk("ar.instret",  instret, 64'd0);
    model_reset();
    @(posedge clk); #1; rst = 0;
    cycle("ar_after");
    int_write(5'd3, 32'h33);                      cycle("ar_run_write");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      in_valid       = ($urandom_range(0, 3) != 0);
      in_reg_write   = $urandom_range(0, 1);
      in_dst_fp      = $urandom_range(0, 1);
      in_dst_addr    = 5'($urandom_range(0, 31));
      in_int_value   = $urandom;
      in_fp_value    = {$urandom, $urandom};
      in_pc          = $urandom;
      in_trap_valid  = ($urandom_range(0, 7) == 0);
      in_trap_cause  = 4'($urandom_range(0, 15));
      in_trap_value  = $urandom;
      in_trap_return = ($urandom_range(0, 7) == 0);
      in_return_priv = 2'($urandom_range(0, 3));
      csr_ack        = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) begin
        instret_we    = 1;
        instret_wdata = ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_FFFF_FFFE
                                                    : {$urandom, $urandom};
      end
      cycle($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_stage.md
# commit_stage

Final in-order pipeline stage, directly downstream of the execute stage. It consumes the execute stage's registered result bundle and writes the integer and FP register files. Trap and trap-return hand-off to the CSR unit uses a request/acknowledge handshake with a small state machine. It also maintains the 64-bit retired-instruction counter (minstret).

## Interface
Parameters:
- `XLEN`, 32: integer datapath width.
- `CAUSE_WIDTH`, 4: exception-cause field width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: execute-stage bundle valid.
- `in_reg_write` in 1: op writes a destination register.
- `in_dst_fp` in 1: 1 = FP destination, 0 = integer destination.
- `in_dst_addr` in 5: destination register index.
- `in_int_value` in XLEN: integer result.
- `in_fp_value` in 64: FP result.
- `in_pc` in XLEN: instruction PC.
- `in_trap_valid` in 1: op raised an exception.
- `in_trap_cause` in CAUSE_WIDTH: exception code.
- `in_trap_value` in XLEN: tval.
- `in_trap_return` in 1: op is MRET/SRET.
- `in_return_priv` in 2: privilege being returned from.
- `int_we` out 1, `int_waddr` out 5, `int_wdata` out XLEN: integer register-file write port.
- `fp_we` out 1, `fp_waddr` out 5, `fp_wdata` out 64: FP register-file write port.
- `trap_req` out 1, `trap_cause` out CAUSE_WIDTH, `trap_value` out XLEN, `trap_pc` out XLEN: trap-entry request to the CSR unit.
- `trap_return_req` out 1, `trap_return_priv` out 2: trap-return request.
- `csr_ack` in 1: CSR unit has accepted the pending request.
- `stall_req` out 1: commit is busy and upstream must not retire.
- `flush_req` out 1: one-cycle pulse that flushes all younger ops.
- `instret_we` in 1, `instret_wdata` in 64: CSR write of minstret.
- `instret` out 64: retired-instruction count.

## Operation
States: RUN, WAIT_ACK, FLUSH. Reset state is RUN.

**RUN**
- A normal op is one with `in_valid=1`, `in_trap_valid=0` and `in_trap_return=0`. It retires this cycle.
- For a normal op, the register write ports are driven combinationally from the inputs:
  - `int_we = in_reg_write & ~in_dst_fp & (in_dst_addr != 0)`. Writes to x0 are suppressed but the op still retires.
  - `fp_we = in_reg_write & in_dst_fp`. f0 is writable.
  - The address and data ports follow the inputs.
- If `in_valid` and (`in_trap_valid` or `in_trap_return`):
  - No register write.
  - Cause, value, pc, return flag and privilege are captured into registers.
  - Next state is WAIT_ACK.
  - If both trap flags are set, trap wins and the return is dropped.

**WAIT_ACK**
- `stall_req=1`.
- Exactly one of `trap_req` or `trap_return_req` is held at 1, with the captured fields, until `csr_ack` is sampled high. Next state is then FLUSH.
- Inputs are ignored (wrong path): no writes, no retire.
- A trap-return retires on ack. A trap does not retire.

**FLUSH**
- `flush_req=1` for exactly one cycle. Inputs are ignored. Next state is RUN.

**Common rules**
- `csr_ack` is ignored outside WAIT_ACK.
- Write ports are 0 outside RUN.

**instret**
- Increments by 1 on each retire. It wraps from 2^64-1 to 0.
- `instret_we` has priority: the counter loads `instret_wdata`, and any retire in that same cycle is not added.

## Timing
- Register-file writes have zero-cycle latency: the write ports are a combinational function of the inputs in RUN.
- `instret` is registered. A retire in cycle N is visible in N+1.
- Trap/return captured at edge N: requests are high from cycle N+1 and are registered outputs. If `csr_ack` is high in cycle M, the requests drop and `flush_req` is high in M+1, and the stage is back in RUN in M+2.
- Minimum trap turnaround is 3 cycles, for `csr_ack` high in the first request cycle.
- Reset values: all outputs 0, `instret` 0, state RUN. Assertion mid-handshake drops the requests immediately, with no flush.

## Test plan
- **Normal writes:** RUN, int write x5=0x1234 in cycle 0 → `int_we=1`, `int_waddr=5`, `int_wdata=0x1234` in cycle 0; `instret` goes 0→1 in cycle 1. Same for FP f0=0x3FF0000000000000 → `fp_we=1`.
- **x0 suppression:** `in_dst_addr=0`, int write → `int_we=0`; `instret` still increments.
- **Trap:** trap cause=2, value=0xDEAD, pc=0x80000010 in cycle 0; `csr_ack` in cycle 3 → `trap_req` high in cycles 1–3 with those fields; `stall_req` high in cycles 1–3; `flush_req` in cycle 4; RUN in cycle 5; `instret` unchanged. A valid int write presented in cycle 2 → `int_we=0`.
- **Trap-return:** MRET with priv=3 → `trap_return_req=1`, `trap_return_priv=3`; on ack, `instret` increments by exactly 1.
- **instret boundaries:** preload `instret=0xFFFFFFFFFFFFFFFF` via `instret_we`, then retire → `instret=0`. `instret_we` with data 7 plus a retire in the same cycle → `instret=7`.
- **Async reset:** assert `rst` mid-cycle during WAIT_ACK → `trap_req`, `stall_req` and `instret` are 0 before the next edge; after release the stage is in RUN.
